// File: rtl/present_pkg.sv
// Shared PRESENT constants and bit-permutation index helpers.
// Also imported by the S-box and key-schedule blocks.
package present_pkg;

    localparam int unsigned PRESENT_WIDTH    = 64;
    localparam int unsigned PRESENT_PERM_MOD = 63;

    typedef enum logic {
        PERM_FWD = 1'b0,
        PERM_INV = 1'b1
    } perm_mode_e;

    // Destination index of input bit idx under the forward pLayer.
    function automatic int unsigned p_fwd(input int unsigned idx);
        return (idx == PRESENT_PERM_MOD) ? PRESENT_PERM_MOD
                                         : (16 * idx) % PRESENT_PERM_MOD;
    endfunction

    // Destination index of input bit idx under the inverse pLayer.
    function automatic int unsigned p_inv(input int unsigned idx);
        return (idx == PRESENT_PERM_MOD) ? PRESENT_PERM_MOD
                                         : (4 * idx) % PRESENT_PERM_MOD;
    endfunction

endpackage

// File: rtl/present_perm_core.sv
// Combinational PRESENT pLayer: forward and inverse bit scatter, selected by inverse.
module present_perm_core
    import present_pkg::*;
(
    input  logic        inverse,
    input  logic [0:63] state,
    output logic [0:63] permuted
);

    logic [0:63] fwd_map;
    logic [0:63] inv_map;

    // The mapping is symmetric under MSB/LSB index reversal, so MSB-first indices apply directly.
    for (genvar j = 0; j < PRESENT_WIDTH; j++) begin : g_bit
        localparam logic [5:0] FWD_DST = 6'(p_fwd(j));
        localparam logic [5:0] INV_DST = 6'(p_inv(j));
        assign fwd_map[FWD_DST] = state[j];
        assign inv_map[INV_DST] = state[j];
    end

    always_comb begin
        permuted = fwd_map;
        if (perm_mode_e'(inverse) == PERM_INV) begin
            permuted = inv_map;
        end
    end

endmodule

// File: rtl/present_p_layer.sv
// Registered PRESENT pLayer: one-cycle latency, one state per clock, optional inverse.
module present_p_layer
    import present_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        inverse,
    input  logic [0:63] state,
    output logic        out_valid,
    output logic [0:63] res
);

    logic [0:63] permuted;

    present_perm_core u_core (
        .inverse  (inverse),
        .state    (state),
        .permuted (permuted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res <= permuted;
            end
        end
    end

endmodule

// File: tb/tb_present_p_layer.sv
// Directed and random checks of present_p_layer against an index-gather reference model.
module tb_present_p_layer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        inverse = 1'b0;
    logic [63:0] state = '0;
    logic        out_valid;
    logic [63:0] res;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    present_p_layer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inverse   (inverse),
        .state     (state),
        .out_valid (out_valid),
        .res       (res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference in LSB numbering: forward scatters, inverse gathers through the forward map.
    function automatic logic [63:0] model(input logic [63:0] s, input logic inv);
        logic [63:0] r;
        int unsigned d;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            d = (i == 63) ? 63 : (i * 16) % 63;
            if (!inv) r[d] = s[i];
            else      r[i] = s[d];
        end
        return r;
    endfunction

    // Drive one input cycle, clock it, sample #1 after the edge.
    task automatic step(input logic v, input logic inv, input logic [63:0] s);
        in_valid = v;
        inverse  = inv;
        state    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic one(input string tag, input logic inv, input logic [63:0] s, input logic [63:0] exp);
        step(1'b1, inv, s);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check(tag, res, exp);
    endtask

    logic [63:0] fwd_vec [5];
    logic [63:0] fwd_exp [5];
    logic [63:0] x, y, prev;
    logic        inv_bit;
    logic [63:0] exp_q [$];

    initial begin
        fwd_vec = '{64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0800_0000_0000_0000,
                    64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
        fwd_exp = '{64'h8000_0000_0000_0000, 64'h0000_8000_0000_0000, 64'h4000_0000_0000_0000,
                    64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001};

        // Reset with in_valid asserted: reset wins.
        step(1'b1, 1'b0, '1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_res", res, 64'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, '1);
        check("idle_valid", 64'(out_valid), 64'd0);
        check("idle_res", res, 64'd0);
        one("first_after_rst", 1'b0, 64'h4000_0000_0000_0000, 64'h0000_8000_0000_0000);

        for (int i = 0; i < 5; i++) one($sformatf("fwd_bit%0d", i), 1'b0, fwd_vec[i], fwd_exp[i]);
        one("fwd_ones", 1'b0, '1, '1);
        one("fwd_zero", 1'b0, '0, '0);
        one("inv_ones", 1'b1, '1, '1);
        one("inv_zero", 1'b1, '0, '0);
        one("inv_bit16", 1'b1, 64'h0000_8000_0000_0000, 64'h4000_0000_0000_0000);

        // Round trip: forward then inverse must restore the input.
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            step(1'b1, 1'b0, x);
            y = res;
            check("rt_fwd", y, model(x, 1'b0));
            step(1'b1, 1'b1, y);
            check("rt_inv", res, x);
        end

        // Streaming, alternating inverse, with a gap and a mid-stream reset.
        for (int i = 0; i < 16; i++) begin
            x = {$urandom, $urandom};
            inv_bit = i[0];
            step(1'b1, inv_bit, x);
            check($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("stream%0d", i), res, model(x, inv_bit));
        end
        prev = res;
        step(1'b0, 1'b1, {$urandom, $urandom});
        check("gap_valid", 64'(out_valid), 64'd0);
        check("gap_hold", res, prev);
        for (int i = 0; i < 4; i++) begin
            x = {$urandom, $urandom};
            step(1'b1, i[0], x);
            check($sformatf("resume%0d", i), res, model(x, i[0]));
        end
        rst = 1'b1;
        step(1'b1, 1'b0, {$urandom, $urandom});
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_res", res, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = {$urandom, $urandom};
            step(1'b1, ~i[0], x);
            check($sformatf("post_rst%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("post_rst%0d", i), res, model(x, ~i[0]));
        end
        step(1'b0, 1'b0, '0);
        check("end_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
